// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: PC generator, instruction memory and decode signals of the fetch unit
interface instr_fetch_unit_if;
  logic [31:0] pc_in;
  logic        PCSrc;
  logic        pc_advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  modport master (
    input  pc_in, PCSrc, imem_rdata, imem_rvalid, instr_ready,
    output pc_advance, imem_req, imem_addr, instr_valid, instr, instr_pc
  );
  modport slave (
    output pc_in, PCSrc, imem_rdata, imem_rvalid, instr_ready,
    input  pc_advance, imem_req, imem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: issues in-order imem reads for the incoming PC and buffers {instr, pc} for decode
module instr_fetch_unit #(
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 2
) (
  input logic               clk,
  input logic               reset,
  instr_fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [TW-1:0] TLAST = TW'(MAX_OUTST - 1);
  logic [63:0]   fifo_q [DEPTH];
  logic [63:0]   fifo_d [DEPTH];
  logic [31:0]   tag_q [MAX_OUTST];
  logic [31:0]   tag_d [MAX_OUTST];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] th_q, th_d, tt_q, tt_d;
  logic [OW-1:0] outst_q, outst_d, drop_q, drop_d;
  logic [63:0]   last_q, last_d, head;
  logic          init_q, init_d;
  logic          blocked, issue, push, pop;
  always_comb begin
    init_d = 1'b0;
    // the cycle right after reset is kept quiet as well as the reset cycles themselves
    blocked = reset | init_q;
    issue = !blocked && !bus.PCSrc && int'(outst_q) < MAX_OUTST
            && int'(count_q) + int'(outst_q) < DEPTH;
    head = fifo_q[rd_q];
    bus.pc_advance = issue;
    bus.imem_req = issue;
    bus.imem_addr = blocked ? '0 : bus.pc_in;
    bus.instr_valid = !blocked && count_q != '0 && !bus.PCSrc;
    {bus.instr, bus.instr_pc} = blocked ? 64'd0 : (count_q != '0 ? head : last_q);
    pop = bus.instr_valid && bus.instr_ready;
    push = bus.imem_rvalid && drop_q == '0 && !bus.PCSrc;
    fifo_d = fifo_q;
    tag_d = tag_q;
    if (push) fifo_d[wr_q] = {bus.imem_rdata, tag_q[th_q]};
    if (issue) tag_d[tt_q] = bus.pc_in;
    rd_d = bus.PCSrc ? '0 : rd_q + AW'(pop);
    wr_d = bus.PCSrc ? '0 : wr_q + AW'(push);
    count_d = bus.PCSrc ? '0 : count_q + CW'(push) - CW'(pop);
    th_d = bus.imem_rvalid ? (th_q == TLAST ? '0 : th_q + 1'b1) : th_q;
    tt_d = issue ? (tt_q == TLAST ? '0 : tt_q + 1'b1) : tt_q;
    outst_d = outst_q + OW'(issue) - OW'(bus.imem_rvalid);
    // on redirect every read still in flight after this cycle belongs to the old stream
    drop_d = bus.PCSrc ? outst_q - OW'(bus.imem_rvalid)
                       : drop_q - OW'(bus.imem_rvalid && drop_q != '0);
    last_d = count_q != '0 ? head : last_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_q <= '{default: '0};
      tag_q <= '{default: '0};
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      th_q <= '0;
      tt_q <= '0;
      outst_q <= '0;
      drop_q <= '0;
      last_q <= '0;
      init_q <= 1'b1;
    end else begin
      fifo_q <= fifo_d;
      tag_q <= tag_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
      th_q <= th_d;
      tt_q <= tt_d;
      outst_q <= outst_d;
      drop_q <= drop_d;
      last_q <= last_d;
      init_q <= init_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized bench with a queue-based reference model and directed scenarios
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;
  localparam int MAX_OUTST = 2;
  typedef struct packed {logic [31:0] pc; logic dead;} infl_t;
  typedef struct packed {logic [31:0] due; logic [31:0] addr;} rsp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  instr_fetch_unit_if bus();
  instr_fetch_unit #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  infl_t       infl[$];
  logic [63:0] fifo[$];
  rsp_t        imem[$];
  logic [63:0] last = '0;
  bit          init = 1'b1;
  logic [31:0] gen_pc = '0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask
  task automatic run_phase(input int id, input int n, input int lat_lo, input int lat_hi,
                           input int ready_pct, input int flush_pct, input int rst_pct,
                           input logic [31:0] rst_pc);
    bit          flush, rdy, rv, blocked, e_issue, e_valid, seen;
    logic [31:0] tgt, rdata, due;
    logic [63:0] e_head;
    infl_t       ent;
    int          adv, h0, h1, h2;
    adv = 0; h0 = 0; h1 = 0; h2 = 0; seen = 1'b0;
    for (int k = -3; k < n; k++) begin
      @(negedge clk);
      reset = (k < 0) || (k > 20 && $urandom_range(99) < rst_pct);
      rdy = (id == 2) ? (k >= 12) : ($urandom_range(99) < ready_pct);
      flush = !reset && ((id == 4) ? (k == 7) : (k > 0 && $urandom_range(99) < flush_pct));
      tgt = (id == 4) ? 32'h40 : ($urandom & 32'h0000_FFFC);
      rv = !reset && imem.size() > 0 && imem[0].due <= 32'(cyc);
      rdata = rv ? word_of(imem[0].addr) : $urandom;
      bus.instr_ready = rdy;
      bus.PCSrc = flush;
      bus.pc_in = gen_pc;
      bus.imem_rvalid = rv;
      bus.imem_rdata = rdata;
      #1;
      blocked = reset || init;
      e_issue = !blocked && !flush && infl.size() < MAX_OUTST && fifo.size() + infl.size() < DEPTH;
      e_valid = !blocked && fifo.size() > 0 && !flush;
      e_head = blocked ? 64'd0 : (fifo.size() > 0 ? fifo[0] : last);
      chk("pc_advance", 32'(bus.pc_advance), 32'(e_issue));
      chk("imem_req", 32'(bus.imem_req), 32'(e_issue));
      chk("imem_addr", bus.imem_addr, blocked ? 32'd0 : gen_pc);
      chk("instr_valid", 32'(bus.instr_valid), 32'(e_valid));
      chk("instr", bus.instr, e_head[63:32]);
      chk("instr_pc", bus.instr_pc, e_head[31:0]);
      if (id == 1 && k >= 1 && k <= 3) chk("sc1_addr", bus.imem_addr, 32'(4 * (k - 1)));
      if (id == 1 && k >= 3 && k <= 5) begin
        chk("sc1_valid", 32'(bus.instr_valid), 32'd1);
        chk("sc1_pc", bus.instr_pc, 32'(4 * (k - 3)));
      end
      if (id == 2 && k < 12 && bus.pc_advance) adv++;
      if (id == 2 && k == 12) chk("sc2_reqs", 32'(adv), 32'd4);
      if (id == 2 && k == 13) chk("sc2_reissue", 32'(bus.pc_advance), 32'd1);
      if (id == 3) begin
        h2 = h1; h1 = h0; h0 = int'(bus.pc_advance);
        if (k >= 0 && k <= 8 && bus.pc_advance) adv++;
        if (k == 9) chk("sc3_reqs", 32'(adv), 32'd4);
        chk("sc3_window", 32'(h0 + h1 + h2 <= 2), 32'd1);
      end
      if (id == 4 && k > 7 && !seen && bus.instr_valid) begin
        seen = 1'b1;
        chk("sc4_pc", bus.instr_pc, 32'h40);
      end
      @(posedge clk);
      if (reset) begin
        infl.delete(); fifo.delete(); imem.delete();
        init = 1'b1; last = '0; gen_pc = rst_pc;
      end else begin
        init = 1'b0;
        if (fifo.size() > 0) last = fifo[0];
        if (e_valid && rdy) void'(fifo.pop_front());
        if (rv) begin
          ent = infl.pop_front();
          void'(imem.pop_front());
          if (!ent.dead && !flush) fifo.push_back({rdata, ent.pc});
        end
        if (flush) begin
          fifo.delete();
          foreach (infl[i]) infl[i].dead = 1'b1;
          gen_pc = tgt;
        end
        if (e_issue) begin
          infl.push_back('{pc: gen_pc, dead: 1'b0});
          due = 32'(cyc + $urandom_range(lat_hi, lat_lo));
          if (imem.size() > 0 && imem[imem.size() - 1].due >= due) due = imem[imem.size() - 1].due + 1;
          imem.push_back('{due: due, addr: gen_pc});
          gen_pc = gen_pc + 4;
        end
      end
      cyc++;
    end
    if (id == 4) chk("sc4_seen", 32'(seen), 32'd1);
  endtask
  initial begin
    bus.pc_in = '0;
    bus.PCSrc = 1'b0;
    bus.imem_rdata = '0;
    bus.imem_rvalid = 1'b0;
    bus.instr_ready = 1'b0;
    run_phase(1, 12, 1, 1, 100, 0, 0, 32'h0);
    run_phase(2, 30, 1, 1, 100, 0, 0, 32'h0);
    run_phase(3, 24, 3, 3, 100, 0, 0, 32'h0);
    run_phase(4, 24, 3, 3, 100, 0, 0, 32'h0);
    run_phase(5, 4000, 1, 4, 60, 6, 1, 32'h1000);
    run_phase(6, 2000, 1, 1, 85, 4, 1, 32'h2000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
